// File: rtl/coh_pkg.sv
// Shared definitions for the coherence dispatcher: line states, beat types
// and the dispatcher FSM encoding.
package coh_pkg;

  localparam logic [1:0] ST_INV = 2'd0;
  localparam logic [1:0] ST_SHR = 2'd1;
  localparam logic [1:0] ST_EXC = 2'd2;
  localparam logic [1:0] ST_MOD = 2'd3;

  localparam logic BEAT_FWD = 1'b0;
  localparam logic BEAT_WB  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_SEND_WB,
    S_SEND_FWD,
    S_ACK
  } dispState_t;

  // After the writeback has cleaned the line, the forward beat reports it as shared.
  function automatic logic [1:0] fwdState(input logic [1:0] st);
    return (st == ST_MOD) ? ST_SHR : st;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or above ptr, wrapping
// from NUM_CH-1 back to 0.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   idx,
  output logic              any
);

  always_comb begin
    int   c;
    logic found;
    c     = 0;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      c = (int'(ptr) + off) % NUM_CH;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = CH_W'(c);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/coh_dispatcher_rr.sv
// Multi-channel coherence dispatcher: round-robin pop from FWFT request queues,
// one or two output beats per transaction, one-hot ack and a saturating counter.
module coh_dispatcher_rr
  import coh_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       En,
  input  logic                       Bus_busy,
  input  logic [NUM_CH-1:0]          Req_empty,
  input  logic [NUM_CH*ADDR_W-1:0]   Req_addr,
  input  logic [NUM_CH*DATA_W-1:0]   Req_data,
  input  logic [NUM_CH*2-1:0]        Req_state,
  output logic [NUM_CH-1:0]          Pull,
  output logic                       Out_valid,
  input  logic                       Out_ready,
  output logic                       Out_type,
  output logic [ADDR_W-1:0]          Out_addr,
  output logic [DATA_W-1:0]          Out_data,
  output logic [1:0]                 Out_state,
  output logic [CH_W-1:0]            Out_ch,
  output logic [NUM_CH-1:0]          Ack,
  output logic [CNT_W-1:0]           Dispatch_cnt
);

  dispState_t state, nextState;

  logic [NUM_CH-1:0] arbGrant;
  logic [CH_W-1:0]   arbIdx;
  logic              arbAny;
  logic [CH_W-1:0]   rrPtr;
  logic [CH_W-1:0]   nextPtr;
  logic              grantValid;

  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latData;
  logic [1:0]        latState;
  logic [CH_W-1:0]   latCh;
  logic [CNT_W-1:0]  cnt;

  logic [ADDR_W-1:0] headAddr;
  logic [DATA_W-1:0] headData;
  logic [1:0]        headState;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) uArb (
    .req   (~Req_empty),
    .ptr   (rrPtr),
    .grant (arbGrant),
    .idx   (arbIdx),
    .any   (arbAny)
  );

  assign headAddr  = Req_addr[int'(arbIdx)*ADDR_W +: ADDR_W];
  assign headData  = Req_data[int'(arbIdx)*DATA_W +: DATA_W];
  assign headState = Req_state[int'(arbIdx)*2 +: 2];

  // No pop strobe while in reset: the entry would be dropped by the reset anyway.
  assign grantValid = (state == S_ARB) && !Rst && En && !Bus_busy && arbAny;
  assign nextPtr    = (int'(latCh) == NUM_CH - 1) ? '0 : CH_W'(latCh + 1'b1);

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:     if (En) nextState = S_ARB;
      S_ARB: begin
        if (!En)             nextState = S_IDLE;
        else if (grantValid) nextState = (headState == ST_MOD) ? S_SEND_WB : S_SEND_FWD;
      end
      S_SEND_WB:  if (Out_ready) nextState = S_SEND_FWD;
      S_SEND_FWD: if (Out_ready) nextState = S_ACK;
      S_ACK:      nextState = S_ARB;
      default:    nextState = S_IDLE;
    endcase
  end

  // The latched copy of the head is what the SEND states replay, so later queue changes are invisible.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      latAddr  <= '0;
      latData  <= '0;
      latState <= ST_INV;
      latCh    <= '0;
      rrPtr    <= '0;
      cnt      <= '0;
    end else begin
      if (grantValid) begin
        latAddr  <= headAddr;
        latData  <= headData;
        latState <= headState;
        latCh    <= arbIdx;
      end
      if (state == S_ACK) begin
        rrPtr <= nextPtr;
        if (cnt != '1) cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    Pull      = '0;
    Out_valid = 1'b0;
    Out_type  = BEAT_FWD;
    Out_addr  = '0;
    Out_data  = '0;
    Out_state = ST_INV;
    Out_ch    = '0;
    Ack       = '0;
    case (state)
      S_ARB: if (grantValid) Pull = arbGrant;
      S_SEND_WB: begin
        Out_valid = 1'b1;
        Out_type  = BEAT_WB;
        Out_state = ST_MOD;
        Out_addr  = latAddr;
        Out_data  = latData;
        Out_ch    = latCh;
      end
      S_SEND_FWD: begin
        Out_valid = 1'b1;
        Out_type  = BEAT_FWD;
        Out_state = fwdState(latState);
        Out_addr  = latAddr;
        Out_data  = latData;
        Out_ch    = latCh;
      end
      S_ACK: begin
        Ack    = NUM_CH'(1) << latCh;
        Out_ch = latCh;
      end
      default: ;
    endcase
  end

  assign Dispatch_cnt = cnt;

endmodule

// File: tb/tb_coh_dispatcher_rr.sv
// Scoreboard bench for coh_dispatcher_rr: queue model drives the request ports,
// a negedge monitor predicts grants, beats, acks and the saturating counter.
module tb_coh_dispatcher_rr;

  localparam int NCH   = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = 2;
  localparam int QDEPTH = 64;

  logic              Clk;
  logic              Rst;
  logic              En;
  logic              Bus_busy;
  logic [NCH-1:0]    Req_empty;
  logic [NCH*AW-1:0] Req_addr;
  logic [NCH*DW-1:0] Req_data;
  logic [NCH*2-1:0]  Req_state;
  logic [NCH-1:0]    Pull;
  logic              Out_valid;
  logic              Out_ready;
  logic              Out_type;
  logic [AW-1:0]     Out_addr;
  logic [DW-1:0]     Out_data;
  logic [1:0]        Out_state;
  logic [1:0]        Out_ch;
  logic [NCH-1:0]    Ack;
  logic [CW-1:0]     Dispatch_cnt;

  coh_dispatcher_rr #(
    .NUM_CH (NCH),
    .ADDR_W (AW),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .En           (En),
    .Bus_busy     (Bus_busy),
    .Req_empty    (Req_empty),
    .Req_addr     (Req_addr),
    .Req_data     (Req_data),
    .Req_state    (Req_state),
    .Pull         (Pull),
    .Out_valid    (Out_valid),
    .Out_ready    (Out_ready),
    .Out_type     (Out_type),
    .Out_addr     (Out_addr),
    .Out_data     (Out_data),
    .Out_state    (Out_state),
    .Out_ch       (Out_ch),
    .Ack          (Ack),
    .Dispatch_cnt (Dispatch_cnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  int assertCnt = 0;
  int failCnt   = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    assertCnt++;
    if (act !== exp) begin
      failCnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-channel FWFT queue model (circular buffers)
  logic [AW-1:0] bufAddr [NCH][QDEPTH];
  logic [DW-1:0] bufData [NCH][QDEPTH];
  logic [1:0]    bufSt   [NCH][QDEPTH];
  int            qHead   [NCH];
  int            qCount  [NCH];

  // Snapshot of what was driven this cycle; the monitor predicts from these
  logic [NCH-1:0] drvEmpty;
  logic [AW-1:0]  drvAddr [NCH];
  logic [DW-1:0]  drvData [NCH];
  logic [1:0]     drvSt   [NCH];
  logic [NCH-1:0] pendingPop;

  task automatic pushEntry(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] st);
    int slot;
    if (qCount[ch] < QDEPTH) begin
      slot = (qHead[ch] + qCount[ch]) % QDEPTH;
      bufAddr[ch][slot] = a;
      bufData[ch][slot] = d;
      bufSt[ch][slot]   = st;
      qCount[ch]++;
    end
  endtask

  task automatic applyStimulus(input bit busy, input bit ready, input bit en, input bit rst);
    @(posedge Clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (pendingPop[i] && qCount[i] > 0) begin
        qHead[i]  = (qHead[i] + 1) % QDEPTH;
        qCount[i] = qCount[i] - 1;
      end
    end
    pendingPop = '0;
    for (int i = 0; i < NCH; i++) begin
      drvEmpty[i] = (qCount[i] == 0);
      drvAddr[i]  = drvEmpty[i] ? '0 : bufAddr[i][qHead[i]];
      drvData[i]  = drvEmpty[i] ? '0 : bufData[i][qHead[i]];
      drvSt[i]    = drvEmpty[i] ? 2'd0 : bufSt[i][qHead[i]];
      Req_addr[i*AW +: AW] = drvAddr[i];
      Req_data[i*DW +: DW] = drvData[i];
      Req_state[i*2 +: 2]  = drvSt[i];
    end
    Req_empty = drvEmpty;
    Bus_busy  = busy;
    Out_ready = ready;
    En        = en;
    Rst       = rst;
  endtask

  // Reference model state
  typedef struct {
    logic          typ;
    logic [1:0]    st;
    logic [1:0]    ch;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  beat_t          expBeats[$];
  int             mPtr;
  int             mCnt;
  bit             mArmed;
  bit             mOut;
  int             ackCh;
  int             ackChNext;
  bit             prevStall;
  logic [127:0]   prevVec;

  function automatic logic [127:0] outVec();
    return {59'd0, Out_valid, Out_type, Out_state, Out_ch, Out_addr, Out_data};
  endfunction

  always @(negedge Clk) begin
    int            g;
    logic [NCH-1:0] expPull;
    logic [NCH-1:0] expAck;
    beat_t         b;
    if (Rst) begin
      expBeats.delete();
      mPtr      = 0;
      mCnt      = 0;
      mArmed    = 1'b0;
      mOut      = 1'b0;
      ackCh     = -1;
      ackChNext = -1;
      prevStall = 1'b0;
      pendingPop = '0;
    end else begin
      g       = -1;
      expPull = '0;
      if (mArmed && En && !Bus_busy && drvEmpty != '1) begin
        for (int k = 0; k < NCH; k++) begin
          if (g < 0 && !drvEmpty[(mPtr + k) % NCH]) g = (mPtr + k) % NCH;
        end
        expPull[g] = 1'b1;
      end
      checkOutput("pull", {124'd0, Pull}, {124'd0, expPull});
      if (g >= 0) begin
        pendingPop = expPull;
        if (drvSt[g] == 2'd3) begin
          b = '{typ: 1'b1, st: 2'd3, ch: 2'(g), addr: drvAddr[g], data: drvData[g], last: 1'b0};
          expBeats.push_back(b);
          b = '{typ: 1'b0, st: 2'd1, ch: 2'(g), addr: drvAddr[g], data: drvData[g], last: 1'b1};
        end else begin
          b = '{typ: 1'b0, st: drvSt[g], ch: 2'(g), addr: drvAddr[g], data: drvData[g], last: 1'b1};
        end
        expBeats.push_back(b);
      end

      if (prevStall) checkOutput("stall_stable", outVec(), prevVec);

      if (Out_valid && Out_ready) begin
        if (expBeats.size() == 0) begin
          checkOutput("unexpected_beat", outVec(), 128'd0);
        end else begin
          b = expBeats.pop_front();
          checkOutput("beat", outVec(), {59'd0, 1'b1, b.typ, b.st, b.ch, b.addr, b.data});
          if (b.last) ackChNext = int'(b.ch);
        end
      end

      expAck = '0;
      if (ackCh >= 0) expAck[ackCh] = 1'b1;
      checkOutput("ack", {124'd0, Ack}, {124'd0, expAck});
      checkOutput("dispatch_cnt", {126'd0, Dispatch_cnt}, 128'(mCnt));

      if (ackCh >= 0) begin
        if (mCnt < 3) mCnt++;
        mPtr = (ackCh + 1) % NCH;
      end

      if (mArmed) begin
        if (!En) mArmed = 1'b0;
        else if (g >= 0) begin
          mArmed = 1'b0;
          mOut   = 1'b1;
        end
      end else if (mOut) begin
        if (ackCh >= 0) begin
          mOut   = 1'b0;
          mArmed = 1'b1;
        end
      end else if (En) begin
        mArmed = 1'b1;
      end

      ackCh     = ackChNext;
      ackChNext = -1;
      prevStall = Out_valid && !Out_ready;
      prevVec   = outVec();
    end
  end

  function automatic bit allIdle();
    bit idle;
    idle = (expBeats.size() == 0) && !mOut && (ackCh < 0);
    for (int i = 0; i < NCH; i++) if (qCount[i] != 0) idle = 1'b0;
    return idle;
  endfunction

  initial begin
    bit found;
    Rst        = 1'b1;
    En         = 1'b0;
    Bus_busy   = 1'b0;
    Out_ready  = 1'b0;
    Req_empty  = '1;
    Req_addr   = '0;
    Req_data   = '0;
    Req_state  = '0;
    pendingPop = '0;
    drvEmpty   = '1;
    for (int i = 0; i < NCH; i++) begin
      qHead[i]  = 0;
      qCount[i] = 0;
    end

    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("reset_outputs", {Pull, Out_valid, Out_type, Out_state, Out_ch, Ack, Dispatch_cnt},
                128'd0);
    checkOutput("reset_addr_data", {Out_addr, Out_data}, 128'd0);

    // Single clean read, then a dirty line on channel 2
    pushEntry(0, 32'h100, 32'hAA, 2'd2);
    repeat (8) applyStimulus(0, 1, 1, 0);
    pushEntry(2, 32'h200, 32'h55, 2'd3);
    repeat (8) applyStimulus(0, 1, 1, 0);

    // Fairness: every channel loaded with two entries
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NCH; c++)
        pushEntry(c, 32'(16'h1000 + r * 16 + c), $urandom, 2'($urandom_range(3, 0)));
    repeat (40) applyStimulus(0, 1, 1, 0);

    // Backpressure on the forward beat
    pushEntry(3, 32'h300, 32'h33, 2'd1);
    applyStimulus(0, 1, 1, 0);
    repeat (7) applyStimulus(0, 0, 1, 0);
    repeat (5) applyStimulus(0, 1, 1, 0);

    // Bus busy holds off the grant
    pushEntry(1, 32'h400, 32'h44, 2'd2);
    repeat (5) applyStimulus(1, 1, 1, 0);
    repeat (6) applyStimulus(0, 1, 1, 0);

    // Randomised traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      if ($urandom_range(99, 0) < 35)
        pushEntry($urandom_range(NCH - 1, 0), $urandom, $urandom, 2'($urandom_range(3, 0)));
      applyStimulus($urandom_range(99, 0) < 20, $urandom_range(99, 0) < 70,
                    $urandom_range(99, 0) < 95, 1'b0);
    end

    found = 1'b0;
    for (int cyc = 0; cyc < 400 && !found; cyc++) begin
      applyStimulus(0, 1, 1, 0);
      if (allIdle()) found = 1'b1;
    end
    checkOutput("drain_done", 128'(found), 128'd1);

    // Reset in the middle of a writeback beat
    pushEntry(2, 32'h500, 32'h77, 2'd3);
    found = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      applyStimulus(0, 0, 1, 0);
      if (Out_valid && Out_type) found = 1'b1;
    end
    checkOutput("wb_reached", 128'(found), 128'd1);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 1, 1, 0);
    checkOutput("post_reset_outputs", {Pull, Out_valid, Out_type, Out_state, Out_ch, Ack, Dispatch_cnt},
                128'd0);
    checkOutput("post_reset_addr_data", {Out_addr, Out_data}, 128'd0);
    repeat (6) applyStimulus(0, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/coh_dispatcher_rr.md
Name: coh_dispatcher_rr

Overview:
Parametrised multi-channel successor of the single-queue coherence dispatcher in the interconnect.
- Arbitrates round-robin over NUM_CH first-word-fall-through request queues and pops one entry per transaction.
- Issues one or two beats on a valid/ready output port, depending on the line state: a MODIFIED line gets a writeback beat followed by a forward beat.
- Returns a one-hot ack to the originating channel.
- Adds features the previous block lacks: a stall-capable output handshake, fair arbitration and a transaction counter.

Parameters:
NUM_CH, 4, number of request channels (>=1)
ADDR_W, 32, address width
DATA_W, 32, data width
CNT_W, 16, width of saturating dispatch counter

Ports:
Clk  in  1  clock
Rst  in  1  reset, synchronous, active-high
En  in  1  enable; leaving IDLE requires En=1
Bus_busy  in  1  write in progress on bus; blocks new grants only
Req_empty  in  NUM_CH  per-channel queue empty flag
Req_addr  in  NUM_CH*ADDR_W  queue head addresses, channel i at [i*ADDR_W +: ADDR_W]
Req_data  in  NUM_CH*DATA_W  queue head data
Req_state  in  NUM_CH*2  head line state: 0 INV, 1 SHR, 2 EXC, 3 MOD
Pull  out  NUM_CH  one-hot pop strobe
Out_valid  out  1  beat valid
Out_ready  in  1  sink accepts beat
Out_type  out  1  0 = forward, 1 = writeback
Out_addr  out  ADDR_W  beat address
Out_data  out  DATA_W  beat data
Out_state  out  2  state carried by beat
Out_ch  out  clog2(NUM_CH) (min 1)  originating channel
Ack  out  NUM_CH  one-hot completion pulse
Dispatch_cnt  out  CNT_W  completed transactions, saturating

Behaviour:
- Reset values:
  - FSM = IDLE, rr pointer = 0, Dispatch_cnt = 0.
  - Pull, Ack, Out_valid, Out_type = 0.
  - Out_addr, Out_data, Out_state, Out_ch = 0.
  - Any latched entry is discarded and no Ack is issued.
- FSM states: IDLE, ARB, SEND_WB, SEND_FWD, ACK.
- IDLE: moves to ARB when En=1.
- ARB:
  - If En=0, go to IDLE.
  - Else if Bus_busy=0 and any Req_empty[i]=0, grant the first non-empty channel at or after the rr pointer, searching upward with wrap NUM_CH-1 -> 0.
  - Pull[g]=1 combinationally for exactly that cycle.
  - Head addr/data/state are latched at the clock edge.
  - Next state is SEND_WB if the latched state is MOD, otherwise SEND_FWD.
  - Otherwise stay in ARB.
- SEND_WB:
  - Out_valid=1, Out_type=1, Out_state=3, latched addr/data.
  - Move to SEND_FWD on the Out_valid&Out_ready edge.
- SEND_FWD:
  - Out_valid=1, Out_type=0, latched addr/data.
  - Out_state = latched state, except MOD is reported as SHR (1).
  - Move to ACK on the handshake edge.
- Output stability: while Out_valid=1 and Out_ready=0, every Out_* signal holds stable. Valid is never withdrawn without a handshake.
- ACK:
  - Ack[g]=1 for one cycle.
  - rr pointer <= (g+1) mod NUM_CH.
  - Dispatch_cnt increments, saturating at all-ones.
  - Next state is ARB.
- Latency: the earliest grant-to-first-beat time is 1 cycle; the minimum transaction is 3 cycles (ARB, SEND_FWD, ACK) or 4 cycles with a writeback.
- Out_ch is driven to g in the SEND states and ACK.
- Mid-transaction inputs:
  - En=0 during SEND/ACK: the transaction completes, then ARB sees En=0 and goes to IDLE.
  - Bus_busy during SEND is ignored.
  - Req_* changes after the grant are ignored; the latched copy is used.
- Edge cases:
  - NUM_CH=1: the pointer stays 0 and Out_ch is 1 bit, always 0.
  - A channel becoming empty in the grant cycle is not possible: the grant is qualified by Req_empty in the same cycle.

Decomposition:
- Shared package coh_pkg holds:
  - line-state localparams ST_INV, ST_SHR, ST_EXC, ST_MOD
  - beat-type constants BEAT_FWD, BEAT_WB
  - FSM state encoding
- One natural sub-module: rr_arbiter. It is a combinational NUM_CH-wide round-robin grant with pointer input, returning the one-hot grant and the encoded index.

Test Plan:
- Single clean read: ch0 nonempty, state=EXC, addr 0x100, data 0xAA, Out_ready=1 -> Pull=0001, one FWD beat (addr 0x100, state 2), Ack=0001 two cycles later, Dispatch_cnt=1.
- Dirty line: ch2 state=MOD, data 0x55 -> WB beat (type 1, state 3, data 0x55), then FWD beat (type 0, state 1), then Ack=0100.
- Fairness: all 4 channels continuously nonempty -> grant order 0, 1, 2, 3, 0, each pulled once per round.
- Backpressure: Out_ready=0 for 5 cycles during SEND_FWD -> Out_valid and Out_* constant for all 5 cycles; exactly one beat accepted; Ack follows.
- Bus_busy=1 with ch1 nonempty -> no Pull while busy; grant in the first cycle after busy clears.
- Reset and saturation: Rst mid-SEND_WB -> next cycle all outputs 0, no Ack. Separately, CNT_W=2 with 5 transactions -> Dispatch_cnt=3.
